// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: pipeline-control, instruction/operand inputs and registered decode outputs of the decode stage
interface alu_decode_stage_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_valid;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_illegal;
  modport master (
    output stall, flush, in_valid, instr, rs_data, rt_data,
    input  ex_valid, ex_aluop, ex_a, ex_b, ex_rd, ex_regwrite, ex_illegal
  );
  modport slave (
    input  stall, flush, in_valid, instr, rs_data, rt_data,
    output ex_valid, ex_aluop, ex_a, ex_b, ex_rd, ex_regwrite, ex_illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered MIPS150 decode producing ALU code, operands and writeback info with stall/flush
module alu_decode_stage #(
  parameter logic RESET_VALID = 1'b0
) (
  input logic clk,
  input logic rst,
  alu_decode_stage_if.slave bus
);
  logic [5:0]  op, fn;
  logic [31:0] se, ze;
  logic        ill, wr;
  logic [3:0]  aluop;
  logic [31:0] a, b;
  logic [4:0]  rd;
  always_comb begin
    op    = bus.instr[31:26];
    fn    = bus.instr[5:0];
    se    = {{16{bus.instr[15]}}, bus.instr[15:0]};
    ze    = {16'b0, bus.instr[15:0]};
    ill   = 1'b0;
    wr    = 1'b1;
    aluop = 4'd0;
    a     = bus.rs_data;
    b     = bus.rt_data;
    rd    = bus.instr[20:16];
    if (op == 6'h00) begin
      rd = bus.instr[15:11];
      case (fn)
        6'h00, 6'h02, 6'h03: begin
          aluop = (fn == 6'h00) ? 4'd8 : (fn == 6'h02) ? 4'd9 : 4'd10;
          a     = bus.rt_data;
          b     = {27'b0, bus.instr[10:6]};
        end
        6'h04, 6'h06, 6'h07: begin
          aluop = (fn == 6'h04) ? 4'd8 : (fn == 6'h06) ? 4'd9 : 4'd10;
          a     = bus.rt_data;
          b     = {27'b0, bus.rs_data[4:0]};
        end
        6'h21:   aluop = 4'd0;
        6'h23:   aluop = 4'd1;
        6'h24:   aluop = 4'd4;
        6'h25:   aluop = 4'd5;
        6'h26:   aluop = 4'd6;
        6'h27:   aluop = 4'd11;
        6'h2a:   aluop = 4'd2;
        6'h2b:   aluop = 4'd3;
        default: ill   = 1'b1;
      endcase
    end else begin
      case (op)
        6'h09:   begin aluop = 4'd0; b = se; end
        6'h0a:   begin aluop = 4'd2; b = se; end
        6'h0b:   begin aluop = 4'd3; b = se; end
        6'h0c:   begin aluop = 4'd4; b = ze; end
        6'h0d:   begin aluop = 4'd5; b = ze; end
        6'h0e:   begin aluop = 4'd6; b = ze; end
        6'h0f:   begin aluop = 4'd7; a = '0; b = ze; end
        6'h23:   begin aluop = 4'd0; b = se; end
        6'h2b:   begin aluop = 4'd0; b = se; wr = 1'b0; end
        6'h04, 6'h05: begin aluop = 4'd1; wr = 1'b0; rd = '0; end
        default: ill = 1'b1;
      endcase
    end
    // unsupported encodings collapse to a harmless valid ADDU 0+0 flagged illegal
    if (ill) begin
      aluop = 4'd0;
      a     = '0;
      b     = '0;
      rd    = '0;
      wr    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid    <= RESET_VALID;
      bus.ex_aluop    <= '0;
      bus.ex_a        <= '0;
      bus.ex_b        <= '0;
      bus.ex_rd       <= '0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_illegal  <= 1'b0;
    end else if (bus.flush || !bus.stall) begin
      bus.ex_valid    <= !bus.flush && bus.in_valid;
      bus.ex_aluop    <= (!bus.flush && bus.in_valid) ? aluop : '0;
      bus.ex_a        <= (!bus.flush && bus.in_valid) ? a : '0;
      bus.ex_b        <= (!bus.flush && bus.in_valid) ? b : '0;
      bus.ex_rd       <= (!bus.flush && bus.in_valid) ? rd : '0;
      bus.ex_regwrite <= !bus.flush && bus.in_valid && wr && (rd != 5'd0);
      bus.ex_illegal  <= !bus.flush && bus.in_valid && ill;
    end
  end
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode stage sitting between the register-file read and the ALU in the MIPS150 pipeline.
- Decodes a 32-bit instruction into the 4-bit ALU control code and selects and extends the two 32-bit ALU operands.
- Also produces destination-register and write-enable information.
- Everything is presented one cycle later, with stall, flush and bubble handling.

Parameters:
- RESET_VALID, 0, value of ex_valid after reset (kept 0 in MIPS150).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all registered outputs unchanged
- flush  in  1  squash: next cycle presents a bubble
- in_valid  in  1  instr/rs_data/rt_data carry a real instruction this cycle
- instr  in  32  instruction word
- rs_data  in  32  register-file value of instr[25:21]
- rt_data  in  32  register-file value of instr[20:16]
- ex_valid  out  1  registered outputs hold a real instruction
- ex_aluop  out  4  ALU control code
- ex_a  out  32  ALU operand A
- ex_b  out  32  ALU operand B
- ex_rd  out  5  destination register number
- ex_regwrite  out  1  result must be written to ex_rd
- ex_illegal  out  1  instruction not supported by the decoder

Behaviour:
- ALU codes come from the shared ALUop header, numerically: ADDU=0, SUBU=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, LUI=7, SLL=8, SRL=9, SRA=10, NOR=11.
- All outputs are registered with a latency of exactly one clk.
- Reset: all outputs are 0 and ex_valid=RESET_VALID. Reset has priority over flush and stall. Reset mid-stall discards the held instruction.
- Update priority per edge: rst > flush > stall > load.
  - Flush, or load with in_valid=0 → bubble: ex_valid=0, ex_regwrite=0, ex_illegal=0, ex_aluop=0, ex_a=0, ex_b=0, ex_rd=0.
  - stall=1 with flush=0 → all outputs keep their previous value. A flush during a stall still produces a bubble.
- Definitions: imm = instr[15:0]; SE = sign-extend imm; ZE = zero-extend imm; shamt = instr[10:6].
- R-type (opcode 0x00): ex_rd = instr[15:11], ex_regwrite=1. Decode by funct:
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: A=rt_data, B={27'b0,shamt}.
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: A=rt_data, B={27'b0,rs_data[4:0]}. Shift amount is masked to 5 bits.
  - 0x21 ADDU, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU: A=rs_data, B=rt_data, matching code.
- I-type: ex_rd = instr[20:16]. A=rs_data unless stated otherwise.
  - 0x09 ADDIU: ADDU, B=SE, write.
  - 0x0A SLTI: SLT, B=SE, write.
  - 0x0B SLTIU: SLTU, B=SE, write.
  - 0x0C ANDI: AND, B=ZE, write.
  - 0x0D ORI: OR, B=ZE, write.
  - 0x0E XORI: XOR, B=ZE, write.
  - 0x0F LUI: LUI, A=0, B=ZE, write.
  - 0x23 LW: ADDU, B=SE, write.
  - 0x2B SW: ADDU, B=SE, no write.
  - 0x04 BEQ, 0x05 BNE: SUBU, B=rt_data, no write, ex_rd=0.
- Any other opcode or funct: ex_illegal=1, ex_valid=1, ex_regwrite=0, ex_aluop=ADDU, ex_a=0, ex_b=0, ex_rd=0.
- Writes to $0 are suppressed: if the decoded rd is 0, ex_regwrite=0. Instruction 0x00000000 (NOP) gives ex_valid=1, ex_regwrite=0.
- No combinational path from any input to any output.

Test Plan:
- Reset and bubble: rst=1 for 2 cycles, then in_valid=0 → all outputs 0 on every cycle.
- ADDU: instr=0x00221821, rs_data=5, rt_data=7 → next cycle ex_valid=1, aluop=0, A=5, B=7, rd=3, regwrite=1.
- Immediate extension:
  - ADDIU instr=0x2422FFFF, rs_data=1 → aluop=0, A=1, B=0xFFFFFFFF, rd=2.
  - ORI instr=0x3422FFFF → aluop=5, B=0x0000FFFF.
  - LUI instr=0x3C021234 → aluop=7, A=0, B=0x00001234.
- Shifts:
  - SRA instr=0x00021903, rt_data=0x80000000 → aluop=10, A=0x80000000, B=4, rd=3.
  - SLLV with rs_data=0x00000123 → B=3.
- Stall and flush: load ADDU, then stall=1 for 3 cycles with different instr → outputs frozen. Then flush=1 together with stall=1 → bubble next cycle.
- Illegal and $0:
  - Opcode 0x3F → ex_illegal=1, ex_valid=1, regwrite=0.
  - ADDU with rd=0 → regwrite=0.
  - BEQ → aluop=1, regwrite=0.
